// File: rtl/mul_div_unit.sv
// +--------------------------------------------------------------------------+
// | mul_div_unit : iterative shift-add multiplier / restoring divider, HI/LO |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH:0]   acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic               is_div_q, neg_lo_q, neg_rem_q, div0_q;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH:0]   mul_next, div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // acc_q holds {upper, lower}: for MULT upper accumulates while the
  // multiplier shifts out of lower; for DIV upper is the partial remainder
  // and lower shifts dividend bits out as quotient bits shift in.
  always_comb begin
    is_signed = (op_i == 3'd0) || (op_i == 3'd2);
    a_neg     = is_signed & rs_data_i[WIDTH-1];
    b_neg     = is_signed & rt_data_i[WIDTH-1];
    abs_a     = a_neg ? -rs_data_i : rs_data_i;
    abs_b     = b_neg ? -rt_data_i : rt_data_i;

    mul_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
    div_next  = div_trial[WIDTH] ? {div_shift, acc_q[WIDTH-2:0], 1'b0}
                                 : {div_trial, acc_q[WIDTH-2:0], 1'b1};

    prod_fix  = neg_lo_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quot_fix  = div0_q ? '1 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    // With a zero divisor the remainder ends as |rs|; restoring its sign gives rs back.
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            case (op_i)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                acc_q     <= {{(WIDTH+1){1'b0}}, abs_a};
                opb_q     <= abs_b;
                is_div_q  <= op_i[1];
                neg_lo_q  <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                div0_q    <= op_i[1] && (rt_data_i == '0);
                cnt_q     <= '0;
                busy_q    <= 1'b1;
                state_q   <= S_ITER;
              end
              3'd4:    hi_q <= rs_data_i;
              3'd5:    lo_q <= rs_data_i;
              default: ;
            endcase
          end
        end
        S_ITER: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!flush_i) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, multi-cycle
// corner sequences (flush, reset, back-to-back), and randomized ops vs a model.
`default_nettype none

module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start_i, flush_i;
  logic [2:0]   op_i;
  logic [W-1:0] rs_data_i, rt_data_i;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [63:0]  mdl;      // model's view of {hi, lo}

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: r = {32'b0, a} * {32'b0, b};
      3'd2: r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd4: r = {a, cur[31:0]};
      3'd5: r = {cur[63:32], a};
      default: r = cur;
    endcase
    return r;
  endfunction

  // Issues a MULT/DIV and leaves the bench in the cycle where done is expected.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc, busy_cnt;
    bit held;
    held = 1'b1;
    busy_cnt = 0;
    start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b;
    tick();
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      if (busy_o) busy_cnt++;
      if ({hi_o, lo_o} !== mdl) held = 1'b0;
      tick();
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(W + 2));
    check({name, " busy cycles"}, 64'(busy_cnt), 64'(W + 1));
    check({name, " hi/lo held"}, 64'(held), 64'd1);
    check({name, " busy in done cycle"}, 64'(busy_o), 64'd0);
    check({name, " result"}, {hi_o, lo_o}, exp);
    mdl = exp;
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] v);
    start_i = 1'b1; op_i = op; rs_data_i = v; rt_data_i = '0;
    tick();
    start_i = 1'b0;
    mdl = ref_model(op, v, 32'd0, mdl);
  endtask

  initial begin
    vec_t vecs[8];
    bit   saw_done;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[5] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; rs_data_i = '0; rt_data_i = '0;
    mdl = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    check("reset hi/lo", {hi_o, lo_o}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
      tick();
      check($sformatf("vec%0d done pulse width", i), 64'(done_o), 64'd0);
    end

    // DIV overflow, then MTHI accepted in the done cycle
    run_op("div overflow", 3'd2, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    move_to(3'd4, 32'h00001234);
    check("mthi in done cycle", {hi_o, lo_o}, {32'h00001234, 32'h80000000});
    check("mthi no busy", 64'(busy_o), 64'd0);

    // Flush mid-MULT; MTLO issued while busy is ignored
    move_to(3'd4, 32'hAAAA5555);
    move_to(3'd5, 32'h12345678);
    start_i = 1'b1; op_i = 3'd0; rs_data_i = 32'd3; rt_data_i = 32'd5;
    tick();                       // T+1
    start_i = 1'b0;
    repeat (4) tick();            // T+5
    start_i = 1'b1; op_i = 3'd5; rs_data_i = 32'hDEADBEEF;
    tick();                       // T+6
    start_i = 1'b0;
    repeat (4) tick();            // T+10
    flush_i = 1'b1;
    tick();                       // T+11
    flush_i = 1'b0;
    check("flush busy drop", 64'(busy_o), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) saw_done = 1'b1;
      tick();
    end
    check("flush no done", 64'(saw_done), 64'd0);
    check("flush hi/lo kept", {hi_o, lo_o}, mdl);

    // Asynchronous reset at T+20 of a DIV
    start_i = 1'b1; op_i = 3'd2; rs_data_i = 32'hFFFFFFF9; rt_data_i = 32'd2;
    tick();                       // T+1
    start_i = 1'b0;
    repeat (19) tick();           // T+20
    rst = 1'b1;
    #1;
    check("async rst busy", 64'(busy_o), 64'd0);
    check("async rst done", 64'(done_o), 64'd0);
    check("async rst hi/lo", {hi_o, lo_o}, 64'd0);
    mdl = '0;
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o || busy_o) saw_done = 1'b1;
      tick();
    end
    check("after rst no activity", 64'(saw_done), 64'd0);

    // Randomized ops against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if (rop <= 3'd3) begin
        run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ref_model(rop, ra, rb, mdl));
        tick();
      end else begin
        move_to(rop, ra);
        check($sformatf("rand%0d op%0d hi/lo", i, rop), {hi_o, lo_o}, mdl);
        check($sformatf("rand%0d op%0d busy", i, rop), 64'(busy_o | done_o), 64'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
